mario_motion: RTL and testbench

- Upstream stage of the VGA colour mapper. Produces the player sprite's centre position (PosX, PosY) and half-extents (SizeX, SizeY) that the mapper consumes as BallX/BallY/Ball_SizeX/Ball_SizeY.
- Advances once per video frame, timed from the VGA vertical-sync pulse.
- Implements walk left/right, jump, gravity, floor landing, ceiling and wall clamps, driven by the USB keyboard keycode.

---
 rtl/mario_motion.sv | 186 ++++++++++++++++++
 tb/tb_mario_motion.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// rtl/mario_motion.sv - player sprite motion: walk, jump, gravity, floor/ceiling/wall limits
//
// Purpose:
//   Produces the player sprite centre (PosX, PosY) and half-extents (SizeX, SizeY)
//   consumed by the VGA colour mapper. Motion advances once per video frame, timed
//   from a synchronised rising edge of the VGA vsync (frame_clk).
//
// Ports:
//   Clk        in   1   system clock
//   Reset      in   1   asynchronous, active-high
//   frame_clk  in   1   VGA vsync, asynchronous to Clk
//   keycode    in   8   current HID key (8'h00 = none), sampled on tick only
//   PosX       out  10  sprite centre X
//   PosY       out  10  sprite centre Y
//   SizeX      out  10  half-width (8)
//   SizeY      out  10  half-height (16)
//   Airborne   out  1   high while not standing on the floor
//
// Build option:
//   MARIO_MOTION_WRAP_EN - when defined, horizontal motion wraps between X_MIN and
//   X_MAX instead of clamping at the walls.

module mario_motion #(
  parameter int           X_START    = 320,
  parameter int           Y_FLOOR    = 463,
  parameter int           X_MIN      = 8,
  parameter int           X_MAX      = 631,
  parameter int           Y_MIN      = 16,
  parameter int           WALK_SPEED = 2,
  parameter int           JUMP_VEL   = 12,
  parameter int           GRAVITY    = 1,
  parameter int           MAX_FALL   = 8,
  parameter logic [7:0]   KEY_LEFT   = 8'h04,
  parameter logic [7:0]   KEY_RIGHT  = 8'h07,
  parameter logic [7:0]   KEY_JUMP   = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [9:0] SizeX,
  output logic [9:0] SizeY,
  output logic       Airborne
);

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;

  // Limits in the signed 12-bit domain used for next-position math.
  localparam logic signed [11:0] X_MIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S   = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN_S   = 12'(Y_MIN);
  localparam logic signed [11:0] Y_FLOOR_S = 12'(Y_FLOOR);
  localparam logic signed [11:0] WALK_S    = 12'(WALK_SPEED);
  localparam logic signed [6:0]  MAX_FALL_S = 7'(MAX_FALL);

  logic        s1_q, s2_q, s3_q;
  logic        tick;

  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic signed [6:0] vel_y_q, vel_y_d;
  logic [1:0]  state_q, state_d;
  logic        airborne_q, airborne_d;

  logic signed [11:0] px, py, nx_left, nx_right, ny, vel_ext;
  logic signed [6:0]  vel_plus;
  logic [3:0]         unused_hi;

  // s1/s2 synchronise vsync; s3 delays s2 so tick is a single-cycle rising-edge pulse.
  assign tick = s2_q & ~s3_q;

  always_comb begin
    px       = $signed({2'b00, pos_x_q});
    py       = $signed({2'b00, pos_y_q});
    vel_ext  = {{5{vel_y_q[6]}}, vel_y_q};
    nx_left  = px - WALK_S;
    nx_right = px + WALK_S;
    ny       = py + vel_ext;
    vel_plus = vel_y_q + 7'(GRAVITY);
    unused_hi = {nx_left[11:10], nx_right[11:10]};

    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vel_y_d    = vel_y_q;
    state_d    = state_q;
    airborne_d = airborne_q;

    if (tick) begin
      if (keycode == KEY_LEFT) begin
        if (nx_left < X_MIN_S) begin
`ifdef MARIO_MOTION_WRAP_EN
          pos_x_d = 10'(X_MAX);
`else
          pos_x_d = 10'(X_MIN);
`endif
        end else begin
          pos_x_d = nx_left[9:0];
        end
      end else if (keycode == KEY_RIGHT) begin
        if (nx_right > X_MAX_S) begin
`ifdef MARIO_MOTION_WRAP_EN
          pos_x_d = 10'(X_MIN);
`else
          pos_x_d = 10'(X_MAX);
`endif
        end else begin
          pos_x_d = nx_right[9:0];
        end
      end

      case (state_q)
        GROUND: begin
          if (keycode == KEY_JUMP) begin
            // Launch frame: height stays put, the velocity takes effect next frame.
            vel_y_d = 7'(-JUMP_VEL);
            state_d = RISE;
          end else begin
            pos_y_d = 10'(Y_FLOOR);
            vel_y_d = '0;
          end
        end
        RISE: begin
          if (ny < Y_MIN_S) begin
            pos_y_d = 10'(Y_MIN);
            vel_y_d = '0;
            state_d = FALL;
          end else begin
            pos_y_d = ny[9:0];
            vel_y_d = vel_plus;
            if (!vel_plus[6]) state_d = FALL;
          end
        end
        FALL: begin
          if (ny >= Y_FLOOR_S) begin
            pos_y_d = 10'(Y_FLOOR);
            vel_y_d = '0;
            state_d = GROUND;
          end else begin
            pos_y_d = ny[9:0];
            vel_y_d = (vel_plus > MAX_FALL_S) ? MAX_FALL_S : vel_plus;
          end
        end
        default: begin
          pos_y_d = 10'(Y_FLOOR);
          vel_y_d = '0;
          state_d = GROUND;
        end
      endcase

      airborne_d = (state_d != GROUND);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      pos_x_q    <= 10'(X_START);
      pos_y_q    <= 10'(Y_FLOOR);
      vel_y_q    <= '0;
      state_q    <= GROUND;
      airborne_q <= 1'b0;
    end else begin
      s1_q       <= frame_clk;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_y_q    <= vel_y_d;
      state_q    <= state_d;
      airborne_q <= airborne_d;
    end
  end

  assign PosX     = pos_x_q;
  assign PosY     = pos_y_q;
  assign SizeX    = 10'd8;
  assign SizeY    = 10'd16;
  assign Airborne = airborne_q;

endmodule

// File: tb/tb_mario_motion.sv
// tb/tb_mario_motion.sv - directed bench for mario_motion (default and low-ceiling instances)
module tb_mario_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;

  logic [9:0] PosX, PosY, SizeX, SizeY;
  logic       Airborne;
  logic [9:0] c_PosX, c_PosY, c_SizeX, c_SizeY;
  logic       c_Airborne;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mario_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .PosX(PosX), .PosY(PosY), .SizeX(SizeX), .SizeY(SizeY), .Airborne(Airborne)
  );

  mario_motion #(.Y_MIN(420)) dut_c (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .PosX(c_PosX), .PosY(c_PosY), .SizeX(c_SizeX), .SizeY(c_SizeY), .Airborne(c_Airborne)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    frame_clk = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // One vsync pulse; returns on a falling Clk edge after the update has landed.
  task automatic frame();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_posx", PosX, 10'd320);
    chk("rst_posy", PosY, 10'd463);
    chk("rst_sizex", SizeX, 10'd8);
    chk("rst_sizey", SizeY, 10'd16);
    chk("rst_air", {9'd0, Airborne}, 10'd0);

    // Tick latency and single tick for a long vsync pulse
    keycode = 8'h07;
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    chk("lat_edge1", PosX, 10'd320);
    @(posedge Clk); #1;
    chk("lat_edge2", PosX, 10'd320);
    @(posedge Clk); #1;
    chk("lat_edge3", PosX, 10'd322);
    repeat (100) @(negedge Clk);
    chk("held_high_one_tick", PosX, 10'd322);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // Walk left to the wall
    do_reset();
    keycode = 8'h04;
    frame();
    chk("walk_l_f1", PosX, 10'd318);
    for (int f = 2; f <= 156; f++) frame();
    chk("walk_l_f156", PosX, 10'd8);
    frame();
`ifdef MARIO_MOTION_WRAP_EN
    chk("walk_l_f157", PosX, 10'd631);
`else
    chk("walk_l_f157", PosX, 10'd8);
`endif

    // Walk right to the wall
    do_reset();
    keycode = 8'h07;
    for (int f = 1; f <= 155; f++) frame();
    chk("walk_r_f155", PosX, 10'd630);
    frame();
    chk("walk_r_f156", PosX, 10'd631);
    frame();
`ifdef MARIO_MOTION_WRAP_EN
    chk("walk_r_f157", PosX, 10'd8);
`else
    chk("walk_r_f157", PosX, 10'd631);
`endif

    // Single jump tap; dut_c has its ceiling at 420
    do_reset();
    keycode = 8'h1A;
    frame();
    keycode = 8'h00;
    chk("jump_f1_air", {9'd0, Airborne}, 10'd1);
    chk("jump_f1_posy", PosY, 10'd463);
    for (int f = 2; f <= 28; f++) begin
      frame();
      if (f == 2)  chk("jump_f2", PosY, 10'd451);
      if (f == 5)  chk("ceil_f5", c_PosY, 10'd421);
      if (f == 6)  chk("ceil_f6", c_PosY, 10'd420);
      if (f == 7)  chk("ceil_f7", c_PosY, 10'd420);
      if (f == 13) chk("jump_f13_apex", PosY, 10'd385);
      if (f == 14) chk("jump_f14", PosY, 10'd385);
      if (f == 16) chk("ceil_f16_land", c_PosY, 10'd463);
      if (f == 16) chk("ceil_f16_air", {9'd0, c_Airborne}, 10'd0);
      if (f == 22) chk("jump_f22", PosY, 10'd421);
      if (f == 27) chk("jump_f27", PosY, 10'd461);
      if (f == 27) chk("jump_f27_air", {9'd0, Airborne}, 10'd1);
    end
    chk("jump_f28_posy", PosY, 10'd463);
    chk("jump_f28_air", {9'd0, Airborne}, 10'd0);
    chk("jump_posx_still", PosX, 10'd320);

    // Jump key held: no re-jump mid-air, relaunch after landing
    do_reset();
    keycode = 8'h1A;
    for (int f = 1; f <= 29; f++) begin
      frame();
      if (f == 13) chk("held_f13", PosY, 10'd385);
      if (f == 27) chk("held_f27", PosY, 10'd461);
      if (f == 28) chk("held_f28_air", {9'd0, Airborne}, 10'd0);
    end
    chk("held_f29_air", {9'd0, Airborne}, 10'd1);
    chk("held_f29_posy", PosY, 10'd463);

    // Asynchronous reset mid-jump
    do_reset();
    keycode = 8'h07;
    frame();
    frame();
    chk("pre_jump_posx", PosX, 10'd324);
    keycode = 8'h1A;
    for (int f = 1; f <= 8; f++) frame();
    chk("mid_f8_posy", PosY, 10'd400);
    @(posedge Clk); #3;
    Reset = 1'b1;
    #1;
    chk("async_posx", PosX, 10'd320);
    chk("async_posy", PosY, 10'd463);
    chk("async_air", {9'd0, Airborne}, 10'd0);
    @(negedge Clk);
    Reset = 1'b0;
    keycode = 8'h00;
    @(negedge Clk);
    frame();
    chk("post_rst_posy", PosY, 10'd463);
    chk("post_rst_air", {9'd0, Airborne}, 10'd0);
    keycode = 8'h1A;
    frame();
    chk("post_rst_jump_air", {9'd0, Airborne}, 10'd1);
    chk("post_rst_jump_posy", PosY, 10'd463);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
